rng_stim_gen: RTL and testbench
===============================

# rng_stim_gen

Parametrised pseudo-random stimulus source for out-of-context builds. It drives arbitrary-width input buses of a design under implementation from a free-running LFSR, so synthesis cannot constant-fold those inputs. It generalises the fixed 32-bit generator with:
- arbitrary output width
- programmable update period
- level or one-cycle pulse output
- tunable bit density, useful for sparse interrupt lines

It is instantiated in `*_random` top-level wrappers in place of the plain generator.

## Interface
- `WIDTH`, 32, output bus width, 1..256.
- `SEED`, 32'h0000_0001, initial LFSR state; 0 is replaced by 1.
- `PERIOD`, 1, requested cycles between output updates, ≥1.
- `MODE`, 0, 0 = level (hold word), 1 = pulse (word visible only on the update cycle).
- `SPARSE`, 0, 0..3; each output bit is the AND of SPARSE+1 random bits, giving set probability 2^-(SPARSE+1).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; low freezes all state.
- `rnd`  out  WIDTH  random stimulus word.
- `upd`  out  1  one-cycle strobe, high in the cycle a new word is presented on `rnd`.

## Operation
- Derived constants:
  - NBITS = WIDTH*(SPARSE+1).
  - CHUNKS = ceil(NBITS/32).
  - P = max(PERIOD, CHUNKS).
- LFSR: 32-bit Galois, right shift, polynomial x^32+x^22+x^2+x+1.
  - Next state = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0).
  - Advances on every enabled cycle.
  - If the state is ever 0, the next state is 1 (lock-up guard).
- Collection buffer `buf`, CHUNKS*32 bits.
  - Each enabled cycle: buf <= {buf[CHUNKS*32-33:0], lfsr}.
  - The new chunk enters at the low end. For CHUNKS = 1: buf <= lfsr.
- Period counter `cnt`, range 0..P-1.
  - Increments on each enabled cycle and wraps P-1 → 0.
  - The enabled cycle with cnt == P-1 is the update cycle.
- Word formation on the update cycle uses `b` = the buffer value *including* that cycle's shift:
  - rnd_next[i] = AND over k = 0..SPARSE of b[i + k*WIDTH].
- Output register:
  - MODE 0: `rnd` loads rnd_next on the update cycle and holds otherwise.
  - MODE 1: `rnd` loads rnd_next on the update cycle and loads 0 on every other cycle.
- `upd` is registered: 1 after the update-cycle edge, 0 after every other edge.
- `en` low:
  - LFSR, buf and cnt hold.
  - `upd` goes 0.
  - In MODE 1 `rnd` goes 0; in MODE 0 `rnd` holds.
  - Counting resumes from the held cnt when `en` returns.
- Reset (asynchronous, at any time, including mid-period):
  - lfsr = SEED (1 if SEED == 0).
  - buf = 0, cnt = 0, rnd = 0, upd = 0.
  - No update is in flight after release.

## Timing
- Edge n means the n-th rising edge with reset low and en high; S_n is the LFSR state after edge n, with S_0 = SEED.
- Updates occur at edges P, 2P, 3P, …
- After edge kP, the low 32 bits of b are S_{kP-1}, the next 32 bits are S_{kP-2}, and so on.
- P ≥ CHUNKS guarantees the first word is built only from LFSR data, never from reset zeros.
- Output latency: `rnd` and `upd` change together, one register stage after the update cycle.
- There is no combinational path from `en` to any output.
- If PERIOD < CHUNKS, the effective interval is CHUNKS cycles; no error is flagged.

## Test plan
- Reset values and first updates (WIDTH=32, PERIOD=1, MODE=0, SPARSE=0, SEED=1):
  - Assert reset mid-run → rnd=0, upd=0 immediately.
  - After release with en=1: edge 1 → rnd=32'h0000_0001, upd=1.
  - Edge 2 → 32'h8020_0003.
  - Edge 3 → 32'hC030_0002.
- Period (PERIOD=4): `upd` high exactly after edges 4, 8, 12.
  - After edge 4, rnd = S_3.
  - `rnd` is stable on all other cycles.
- Pulse mode (MODE=1, PERIOD=3): `rnd` is nonzero only in cycles where upd=1, and equals S_{3k-1} there.
- Wide plus sparse (WIDTH=40, SPARSE=1; NBITS=80, CHUNKS=3, P=3):
  - First update after edge 3.
  - rnd[i] = b[i] & b[i+40], checked against a reference LFSR model.
  - Over 10 000 updates the density is within 0.25 ± 0.02.
- Enable stall: drop en for 5 cycles at cnt=1 (PERIOD=4).
  - upd=0 and the LFSR is frozen throughout.
  - The next update comes 3 enabled cycles after en returns, with the value the model predicts ignoring the stall.
- Zero seed (SEED=0): behaviour is identical to SEED=1; the LFSR never reaches 0 over 2^16 cycles.

Source files
------------

// File: rtl/rng_stim_gen.sv
// Pseudo-random stimulus source: 32-bit Galois LFSR feeding a chunk buffer, with
// programmable update period, level/pulse output and AND-based bit sparsening.
module rng_stim_gen #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [31:0] SEED   = 32'h0000_0001,
  parameter int unsigned PERIOD = 1,
  parameter int unsigned MODE   = 0,
  parameter int unsigned SPARSE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] rnd,
  output logic             upd
);

  localparam int unsigned NBITS  = WIDTH * (SPARSE + 1);
  localparam int unsigned CHUNKS = (NBITS + 31) / 32;
  localparam int unsigned P      = (PERIOD > CHUNKS) ? PERIOD : CHUNKS;
  localparam int unsigned CW     = (P > 1) ? $clog2(P) : 1;
  localparam logic [31:0] SEED0  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] TAPS   = 32'h8020_0003;

  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic [NBITS-1:0] b;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [WIDTH-1:0] rnd_next;

  always_comb begin
    lfsr_next = '0;
    if (lfsr == '0)
      lfsr_next = 32'd1;
    else
      lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'd0);
  end

  // Only the low NBITS of the collection buffer are ever observed, so only
  // those bits are kept; b is the buffer value including this cycle's shift.
  if (NBITS > 32) begin : g_hist
    logic [NBITS-33:0] hist;
    assign b = {hist, lfsr};
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        hist <= '0;
      else if (en)
        hist <= b[NBITS-33:0];
    end
  end else begin : g_nohist
    assign b = lfsr[NBITS-1:0];
  end

  assign last = (cnt == CW'(P - 1));

  always_comb begin
    rnd_next = '1;
    for (int unsigned k = 0; k <= SPARSE; k++)
      rnd_next = rnd_next & b[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED0;
      cnt  <= '0;
      rnd  <= '0;
      upd  <= 1'b0;
    end else if (en) begin
      lfsr <= lfsr_next;
      cnt  <= last ? '0 : cnt + CW'(1);
      upd  <= last;
      if (last)
        rnd <= rnd_next;
      else if (MODE == 1)
        rnd <= '0;
    end else begin
      upd <= 1'b0;
      if (MODE == 1)
        rnd <= '0;
    end
  end

endmodule

// File: tb/tb_rng_stim_gen.sv
// Self-checking bench for rng_stim_gen: several parameterisations share clock,
// reset and enable; expectations come from an LFSR state-history model.
module tb_rng_stim_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [31:0] r0, r1, r2, r4;
  logic [39:0] r3;
  logic        u0, u1, u2, u3, u4;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] hist[$];

  always #5 clk = ~clk;

  rng_stim_gen #(.WIDTH(32), .SEED(32'h1), .PERIOD(1), .MODE(0), .SPARSE(0))
    dut0 (.clk(clk), .reset(reset), .en(en), .rnd(r0), .upd(u0));
  rng_stim_gen #(.WIDTH(32), .SEED(32'h1), .PERIOD(4), .MODE(0), .SPARSE(0))
    dut1 (.clk(clk), .reset(reset), .en(en), .rnd(r1), .upd(u1));
  rng_stim_gen #(.WIDTH(32), .SEED(32'h1), .PERIOD(3), .MODE(1), .SPARSE(0))
    dut2 (.clk(clk), .reset(reset), .en(en), .rnd(r2), .upd(u2));
  rng_stim_gen #(.WIDTH(40), .SEED(32'h1), .PERIOD(1), .MODE(0), .SPARSE(1))
    dut3 (.clk(clk), .reset(reset), .en(en), .rnd(r3), .upd(u3));
  rng_stim_gen #(.WIDTH(32), .SEED(32'h0), .PERIOD(1), .MODE(0), .SPARSE(0))
    dut4 (.clk(clk), .reset(reset), .en(en), .rnd(r4), .upd(u4));

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    if (s == 32'd0) return 32'd1;
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  // S_{n-k} after edge n (hist tail is S_n)
  function automatic logic [31:0] st(input int k);
    return hist[hist.size() - 1 - k];
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    en = 1'b1;
    hist = {};
    hist.push_back(32'd1);
  endtask

  task automatic adv();
    @(posedge clk); #1;
    hist.push_back(lfsr_step(hist[hist.size()-1]));
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic test_reset();
    logic [31:0] exp_w[3];
    exp_w[0] = 32'h0000_0001;
    exp_w[1] = 32'h8020_0003;
    exp_w[2] = 32'hC030_0002;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    en = 1'b1;
    repeat (6) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks += 6;
    if (r0 !== 32'd0) begin errors++; $display("FAIL reset_rnd0 got %h expected 0", r0); end
    if (u0 !== 1'b0)  begin errors++; $display("FAIL reset_upd0 got %b expected 0", u0); end
    if (r1 !== 32'd0) begin errors++; $display("FAIL reset_rnd1 got %h expected 0", r1); end
    if (u1 !== 1'b0)  begin errors++; $display("FAIL reset_upd1 got %b expected 0", u1); end
    if (r2 !== 32'd0) begin errors++; $display("FAIL reset_rnd2 got %h expected 0", r2); end
    if (r3 !== 40'd0) begin errors++; $display("FAIL reset_rnd3 got %h expected 0", r3); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks += 2;
      if (r0 !== exp_w[i]) begin
        errors++; $display("FAIL first_words edge=%0d got %h expected %h", i+1, r0, exp_w[i]);
      end
      if (u0 !== 1'b1) begin
        errors++; $display("FAIL first_upd edge=%0d got %b expected 1", i+1, u0);
      end
    end
  endtask

  task automatic test_period();
    logic [31:0] held = '0;
    apply_reset();
    for (int n = 1; n <= 40; n++) begin
      adv();
      if (n % 4 == 0) held = st(1);
      checks += 2;
      if (u1 !== (n % 4 == 0)) begin
        errors++; $display("FAIL period_upd n=%0d got %b expected %b", n, u1, (n % 4 == 0));
      end
      if (r1 !== held) begin
        errors++; $display("FAIL period_rnd n=%0d got %h expected %h", n, r1, held);
      end
    end
  endtask

  task automatic test_pulse();
    logic [31:0] e;
    apply_reset();
    for (int n = 1; n <= 30; n++) begin
      adv();
      e = (n % 3 == 0) ? st(1) : 32'd0;
      checks += 2;
      if (u2 !== (n % 3 == 0)) begin
        errors++; $display("FAIL pulse_upd n=%0d got %b expected %b", n, u2, (n % 3 == 0));
      end
      if (r2 !== e) begin
        errors++; $display("FAIL pulse_rnd n=%0d got %h expected %h", n, r2, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held = '0;
    apply_reset();
    for (int n = 1; n <= 13; n++) begin
      if (n == 6) begin
        en = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          checks += 2;
          if (u1 !== 1'b0) begin errors++; $display("FAIL stall_upd cyc=%0d got %b expected 0", s, u1); end
          if (r1 !== held) begin errors++; $display("FAIL stall_rnd cyc=%0d got %h expected %h", s, r1, held); end
        end
        en = 1'b1;
      end
      adv();
      if (n % 4 == 0) held = st(1);
      checks += 2;
      if (u1 !== (n % 4 == 0)) begin
        errors++; $display("FAIL resume_upd n=%0d got %b expected %b", n, u1, (n % 4 == 0));
      end
      if (r1 !== held) begin
        errors++; $display("FAIL resume_rnd n=%0d got %h expected %h", n, r1, held);
      end
    end
  endtask

  task automatic test_sparse_and_zero_seed();
    logic [95:0] b;
    logic [39:0] e3 = '0;
    longint unsigned ones = 0;
    longint unsigned nupd = 0;
    longint unsigned dens;
    bit stop = 0;
    apply_reset();
    for (int n = 1; n <= 65536 && !stop; n++) begin
      if (n == 7 || ($urandom_range(0, 99) == 0 && n > 12)) begin
        // random single-cycle stalls must not perturb either stream
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
      end
      adv();
      if (n % 3 == 0) begin
        b = {st(3), st(2), st(1)};
        e3 = b[39:0] & b[79:40];
      end
      checks += 4;
      if (u3 !== (n % 3 == 0)) begin
        errors++; $display("FAIL sparse_upd n=%0d got %b expected %b", n, u3, (n % 3 == 0));
      end
      if (r3 !== e3) begin
        errors++; $display("FAIL sparse_rnd n=%0d got %h expected %h", n, r3, e3);
      end
      if (u4 !== 1'b1) begin
        errors++; $display("FAIL zseed_upd n=%0d got %b expected 1", n, u4);
      end
      if (r4 !== st(1)) begin
        errors++; $display("FAIL zseed_rnd n=%0d got %h expected %h", n, r4, st(1));
      end
      if (n % 3 == 0) begin
        ones += $countones(r3);
        nupd++;
      end
      if (errors > 20) stop = 1;
    end
    dens = (nupd == 0) ? 0 : (ones * 1000) / (nupd * 40);
    checks++;
    if (nupd < 10000 || dens < 230 || dens > 270) begin
      errors++; $display("FAIL sparse_density updates=%0d got %0d/1000 expected 230..270", nupd, dens);
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_pulse();
    test_stall();
    test_sparse_and_zero_seed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
